// File: rtl/shaper_peak_ctrl.sv
// ---------------------------------------------------------------------------
// shaper_peak_ctrl
// Event controller behind the trapezoidal shaping filter. Arms on a signed
// threshold, tracks each pulse to its maximum, flags pile-up when a pulse
// outlasts max_width, enforces a dead-time holdoff after every event and
// queues {peak, timestamp, pileup} in a show-ahead FIFO drained over
// valid/ready.
//
// Ports
//   clk          sample clock, one filter sample per cycle
//   reset        asynchronous, active-low
//   enable       1 = run detection, 0 = force IDLE (FIFO keeps draining)
//   filter_data  signed shaper output
//   threshold    signed arm level
//   holdoff      dead-time cycles after each event (0 behaves as 1)
//   max_width    pulse length forcing a pile-up exit (0 = disabled)
//   evt_ready    consumer accepts the head event
//   evt_valid    FIFO non-empty
//   evt_peak     head event peak value
//   evt_time     head event timestamp of the peak sample
//   evt_pileup   head event was width-terminated
//   fifo_level   number of stored events
//   overflow_cnt events dropped on a full FIFO (saturating)
//   busy         detector is in TRACK or HOLDOFF
// ---------------------------------------------------------------------------
module shaper_peak_ctrl #(
  parameter int FILTER_W   = 16,
  parameter int TS_W       = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [FILTER_W-1:0]         filter_data,
  input  logic [FILTER_W-1:0]         threshold,
  input  logic [15:0]                 holdoff,
  input  logic [15:0]                 max_width,
  input  logic                        evt_ready,
  output logic                        evt_valid,
  output logic [FILTER_W-1:0]         evt_peak,
  output logic [TS_W-1:0]             evt_time,
  output logic                        evt_pileup,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [15:0]                 overflow_cnt,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    TRACK   = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t              state_r;
  logic                busy_r;
  logic [FILTER_W-1:0] peak_r;
  logic [TS_W-1:0]     peak_time_r;
  logic [TS_W-1:0]     ts_r;
  logic [15:0]         width_r;
  logic [15:0]         hold_cnt_r;

  logic [FILTER_W-1:0] mem_peak_r [FIFO_DEPTH];
  logic [TS_W-1:0]     mem_time_r [FIFO_DEPTH];
  logic                mem_pile_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [LW-1:0]       level_r;
  logic                valid_r;
  logic [15:0]         ovf_r;

  logic                above_s;
  logic                bigger_s;
  logic [15:0]         width_inc_s;
  logic                pile_s;
  logic                push_s;
  logic [15:0]         hold_init_s;
  logic                pop_s;
  logic                full_s;
  logic                wr_en_s;
  logic                drop_s;
  logic [LW-1:0]       level_next_s;

  // Detection decode; all compares are signed at FILTER_W.
  assign above_s     = $signed(filter_data) > $signed(threshold);
  assign bigger_s    = $signed(filter_data) > $signed(peak_r);
  assign width_inc_s = (width_r == 16'hFFFF) ? 16'hFFFF : (width_r + 16'd1);
  // width_inc_s counts the current sample, so the exit fires on the
  // max_width-th sample above threshold; that sample is not folded into peak.
  assign pile_s      = above_s && (max_width != 16'd0) && (width_inc_s >= max_width);
  assign push_s      = enable && (state_r == TRACK) && (!above_s || pile_s);
  assign hold_init_s = (holdoff == 16'd0) ? 16'd1 : holdoff;

  // FIFO handshake decode; a pop frees the slot a same-cycle push needs.
  assign pop_s        = valid_r && evt_ready;
  assign full_s       = (level_r == LW'(FIFO_DEPTH));
  assign wr_en_s      = push_s && (!full_s || pop_s);
  assign drop_s       = push_s && full_s && !pop_s;
  assign level_next_s = (wr_en_s && !pop_s) ? (level_r + LW'(1)) :
                        (!wr_en_s && pop_s) ? (level_r - LW'(1)) : level_r;

  // Free-running timestamp, independent of enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ts_r <= '0;
    end else begin
      ts_r <= ts_r + TS_W'(1);
    end
  end

  // Detector FSM: arm, track peak/width, holdoff; busy follows the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      peak_r      <= '0;
      peak_time_r <= '0;
      width_r     <= 16'd0;
      hold_cnt_r  <= 16'd0;
    end else if (!enable) begin
      // Any in-progress pulse is abandoned without a push.
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= ARMED;
          busy_r  <= 1'b0;
        end
        ARMED: begin
          if (above_s) begin
            state_r     <= TRACK;
            busy_r      <= 1'b1;
            peak_r      <= filter_data;
            peak_time_r <= ts_r;
            width_r     <= 16'd1;
          end else begin
            busy_r <= 1'b0;
          end
        end
        TRACK: begin
          busy_r <= 1'b1;
          if (!above_s || pile_s) begin
            state_r    <= HOLDOFF;
            hold_cnt_r <= hold_init_s;
          end else begin
            width_r <= width_inc_s;
            // Strict compare keeps the first occurrence of a tied maximum.
            if (bigger_s) begin
              peak_r      <= filter_data;
              peak_time_r <= ts_r;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt_r <= 16'd1) begin
            state_r <= ARMED;
            busy_r  <= 1'b0;
          end else begin
            hold_cnt_r <= hold_cnt_r - 16'd1;
            busy_r     <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Event FIFO storage, pointers, level and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_peak_r[i] <= '0;
        mem_time_r[i] <= '0;
        mem_pile_r[i] <= 1'b0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 16'd0;
    end else begin
      if (wr_en_s) begin
        mem_peak_r[wr_ptr_r] <= peak_r;
        mem_time_r[wr_ptr_r] <= peak_time_r;
        mem_pile_r[wr_ptr_r] <= above_s;
        wr_ptr_r             <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
      valid_r <= (level_next_s != '0);
      if (drop_s && (ovf_r != 16'hFFFF)) begin
        ovf_r <= ovf_r + 16'd1;
      end
    end
  end

  assign evt_valid    = valid_r;
  assign evt_peak     = mem_peak_r[rd_ptr_r];
  assign evt_time     = mem_time_r[rd_ptr_r];
  assign evt_pileup   = mem_pile_r[rd_ptr_r];
  assign fifo_level   = level_r;
  assign overflow_cnt = ovf_r;
  assign busy         = busy_r;

endmodule

// File: doc/shaper_peak_ctrl.md
# shaper_peak_ctrl

Event controller behind the trapezoidal shaping filter. It watches the filter output stream and arms on a programmable threshold. It tracks each pulse to its maximum, flags pile-up, and enforces a dead-time holdoff. Each event is queued as {peak, timestamp, pileup} in a small FIFO, which drains to the readout over a valid/ready handshake.

## Interface
- FILTER_W, 16: width of filter sample, threshold and peak (signed two's complement)
- TS_W, 32: width of free-running timestamp
- FIFO_DEPTH, 8: event FIFO entries (power of two, ≥2)
- clk  in  1  sample clock; one filter sample per cycle
- reset  in  1  asynchronous, active-low
- enable  in  1  1 = run detection; 0 = force IDLE
- filter_data  in  FILTER_W  signed shaper output, valid every cycle
- threshold  in  FILTER_W  signed arm level; static while enable=1
- holdoff  in  16  dead-time cycles after each event
- max_width  in  16  pulse cycles before pile-up is forced; 0 = disabled
- evt_ready  in  1  consumer accepts event
- evt_valid  out  1  FIFO non-empty
- evt_peak  out  FILTER_W  peak value of head event
- evt_time  out  TS_W  timestamp of head event's peak sample
- evt_pileup  out  1  head event was width-terminated
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries stored
- overflow_cnt  out  16  events dropped on full FIFO; saturates at 0xFFFF
- busy  out  1  state is TRACK or HOLDOFF

## Operation
- Reset: every output is 0, the FIFO is empty, the timestamp is 0 and the state is IDLE.
- Timestamp: increments every cycle regardless of enable, wraps modulo 2^TS_W.
- States:
  - IDLE: left for ARMED when enable=1.
  - ARMED: moves to TRACK when filter_data > threshold (strict, signed). On entry to TRACK, peak := sample, peak_time := ts, width := 1.
  - TRACK, while filter_data > threshold: width increments. If sample > peak (strict), peak and peak_time update, so ties keep the first occurrence.
  - TRACK exit on sample ≤ threshold: push {peak, peak_time, 0} and go to HOLDOFF.
  - TRACK exit on width reaching max_width (max_width≠0) with sample still > threshold: push {peak, peak_time, 1} and go to HOLDOFF. The sample that triggers the exit is not compared into peak.
  - HOLDOFF: lasts max(holdoff,1) cycles, then goes to ARMED. It ignores filter_data, so a sample above threshold on return to ARMED re-triggers immediately.
- enable=0 in any state: next state is IDLE. An in-progress TRACK is discarded without a push. The FIFO keeps its contents and continues to drain.
- FIFO is show-ahead: the evt_* fields present the head entry whenever evt_valid=1.
  - Pop occurs on evt_valid & evt_ready.
  - Push while full with no pop in the same cycle: event dropped and overflow_cnt += 1 (saturating).
  - Simultaneous push and pop when full: both take effect, level unchanged, no drop.
  - Push and pop when empty: push only; evt_valid rises next cycle.
- Arithmetic: all compares are signed at FILTER_W. Width counter is 16-bit and saturates.

## Timing
- Sample at or below threshold ending a pulse, presented in cycle n: state is HOLDOFF and evt_valid=1 in cycle n+1 (FIFO previously empty).
- Forced pile-up: the push happens at the edge ending the cycle in which width = max_width, i.e. the max_width-th sample above threshold.
- Holdoff h≥1: after the exit edge, h cycles in HOLDOFF, and the first compare in ARMED is the sample at cycle n+1+h.
- fifo_level, evt_valid and overflow_cnt update at the same edge as push and pop.
- Reset deasserted mid-pulse: detection restarts in IDLE, and the first compare happens one cycle after enable is seen in IDLE.
- No combinational path from filter_data or evt_ready to any output.

## Test plan
- threshold=100, holdoff=4, pulse 50,120,300,450,450,200,80 -> one event peak=450, time = ts of first 450, pileup=0; evt_valid one cycle after the 80 sample.
- max_width=3, threshold=0, constant input 500 for 20 cycles -> event pileup=1 after the 3rd sample; after holdoff, re-triggers and repeats.
- evt_ready=0, 10 pulses, FIFO_DEPTH=8 -> fifo_level=8, overflow_cnt=2; drain returns 8 events in order with increasing timestamps.
- FIFO full with push and pop in the same cycle -> level stays 8, overflow_cnt unchanged, the new event appears last.
- enable dropped mid-TRACK -> no event, state IDLE, stored events still drained; reset asserted mid-pulse -> all outputs 0 at once.
- Negative baseline -200, threshold=-50, pulse to -10 -> event peak=-10 (signed compare verified).
